// File: rtl/isa_pkg.sv
// Shared ISA-level sizes and register-file state encoding.
// Imported by the register file and its scoreboard.
package isa;

  localparam int XLEN     = 32;
  localparam int RCNT_LOG = 5;
  localparam int RCNT     = 1 << RCNT_LOG;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

endpackage

// File: rtl/register_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Issue sets, writeback clears, set wins on collision.
module rf_scoreboard
  import isa::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run_i,
  input  logic                wr_en_i,
  input  logic [RCNT_LOG-1:0] wr_addr_i,
  input  logic                issue_en_i,
  input  logic [RCNT_LOG-1:0] issue_addr_i,
  input  logic [RCNT_LOG-1:0] rs1_addr_i,
  input  logic [RCNT_LOG-1:0] rs2_addr_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o
);

  logic [RCNT-1:0] busy_q;
  logic [RCNT-1:0] busy_d;
  logic            wr_hit1;
  logic            wr_hit2;

  // Next busy vector: clear on writeback, then set on issue.
  always_comb begin
    busy_d = busy_q;
    if (run_i) begin
      if (wr_en_i && wr_addr_i != '0)
        busy_d[wr_addr_i] = 1'b0;
      if (issue_en_i && issue_addr_i != '0)
        busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  // A same-cycle writeback clears the lookup.
  assign wr_hit1 = wr_en_i && (wr_addr_i == rs1_addr_i);
  assign wr_hit2 = wr_en_i && (wr_addr_i == rs2_addr_i);

  assign rs1_busy_o = run_i && !wr_hit1 && busy_q[rs1_addr_i];
  assign rs2_busy_o = run_i && !wr_hit2 && busy_q[rs2_addr_i];

endmodule

// File: rtl/register_file.sv
// Integer register file, two bypassed reads, one write.
// Sweeps x1..x31 to zero after reset before running.
module register_file
  import isa::*;
(
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [RCNT_LOG-1:0] wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                wr_enable,
  input  logic [RCNT_LOG-1:0] rs1_addr,
  input  logic [RCNT_LOG-1:0] rs2_addr,
  output logic [XLEN-1:0]     rs1,
  output logic [XLEN-1:0]     rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                issue_enable,
  input  logic [RCNT_LOG-1:0] issue_rd_addr
);

  localparam logic [RCNT_LOG-1:0] LAST = RCNT_LOG'(RCNT - 1);

  rf_state_t           state_q;
  logic [RCNT_LOG-1:0] idx_q;
  logic                ready_q;
  logic [XLEN-1:0]     regs_q [1:RCNT-1];

  logic                run;
  logic                we_d;
  logic [RCNT_LOG-1:0] waddr_d;
  logic [XLEN-1:0]     wdata_d;

  assign run   = (state_q == RF_RUN);
  assign ready = ready_q;

  // Clear FSM: walk the sweep index, then hand over to run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      idx_q   <= RCNT_LOG'(1);
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          idx_q <= idx_q + RCNT_LOG'(1);
          if (idx_q == LAST) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= RF_CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array write port shared by the sweep and writeback.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = wr_addr;
    wdata_d = wr_data;
    if (!reset) begin
      if (state_q == RF_CLEAR) begin
        we_d    = 1'b1;
        waddr_d = idx_q;
        wdata_d = '0;
      end else if (wr_enable && wr_addr != '0) begin
        we_d = 1'b1;
      end
    end
  end

  // Storage array for x1..x31.
  always_ff @(posedge clk) begin
    if (we_d && waddr_d != '0)
      regs_q[waddr_d] <= wdata_d;
  end

  // Read muxes with writeback bypass; x0 and sweep read as 0.
  always_comb begin
    rs1 = '0;
    rs2 = '0;
    if (run && rs1_addr != '0) begin
      if (wr_enable && wr_addr == rs1_addr)
        rs1 = wr_data;
      else
        rs1 = regs_q[rs1_addr];
    end
    if (run && rs2_addr != '0) begin
      if (wr_enable && wr_addr == rs2_addr)
        rs2 = wr_data;
      else
        rs2 = regs_q[rs2_addr];
    end
  end

  rf_scoreboard u_sb (
    .clk          (clk),
    .reset        (reset),
    .run_i        (run),
    .wr_en_i      (wr_enable),
    .wr_addr_i    (wr_addr),
    .issue_en_i   (issue_enable),
    .issue_addr_i (issue_rd_addr),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy)
  );

endmodule
